// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: FSM states,
// opcode values and the datapath select encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMREAD,
        ST_MEMWB,
        ST_MEMWRITE,
        ST_EXECR,
        ST_EXECI,
        ST_ALUWB,
        ST_BRANCH,
        ST_JAL,
        ST_JALR,
        ST_LUI,
        ST_AUIPC,
        ST_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10,
        SRCA_ZERO  = 2'b11
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_RTYPE  = 2'b10,
        ALUOP_ITYPE  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT  = 2'b00,
        RES_MEMDATA = 2'b01,
        RES_ALU     = 2'b10
    } result_src_t;

    // Opcode dispatch out of DECODE; anything unsupported lands in TRAP.
    function automatic state_t decode_next(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD,
            OP_STORE:  return ST_MEMADR;
            OP_RTYPE:  return ST_EXECR;
            OP_ITYPE:  return ST_EXECI;
            OP_BRANCH: return ST_BRANCH;
            OP_JAL:    return ST_JAL;
            OP_JALR:   return ST_JALR;
            OP_LUI:    return ST_LUI;
            OP_AUIPC:  return ST_AUIPC;
            default:   return ST_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Bounds a memory handshake: counts cycles a request waits without ready and
// flags expiry on the WAIT_MAX-th consecutive waiting cycle. A ready in that
// same cycle is not a wait, so it suppresses the expiry.
module mem_watchdog #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ready,
    input  logic clear,
    output logic expire
);

    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting = req & ~ready;
    assign expire  = waiting && (cnt == CNT_W'(WAIT_MAX - 1));

    // Wait counter: restarts whenever the controller leaves its current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            cnt <= '0;
        end else if (waiting) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Steps one shared memory
// port, the ALU and the register file through FETCH/DECODE/EXECUTE/MEM/WB and
// drives Moore datapath selects from the current state.
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        br_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  result_src,
    output logic        illegal,
    output logic        bus_err
);

    state_t      state;
    state_t      state_next;
    src_a_t      src_a_sel;
    src_b_t      src_b_sel;
    alu_op_t     alu_op_sel;
    result_src_t result_sel;
    logic        in_mem_access;
    logic        wd_expire;
    logic        set_illegal;
    logic        set_bus_err;
    logic [6:0]  opcode;

    assign opcode = instr[6:0];

    // Memory-access states: the watchdog only runs while one of these holds mem_req.
    assign in_mem_access = (state == ST_FETCH) || (state == ST_MEMREAD) ||
                           (state == ST_MEMWRITE);

    mem_watchdog #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .req    (in_mem_access),
        .ready  (mem_ready),
        .clear  (state_next != state),
        .expire (wd_expire)
    );

    // State register; reset lands in IDLE, which drops every output at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (set_illegal) illegal <= 1'b1;
            if (set_bus_err) bus_err <= 1'b1;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next  = state;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        src_a_sel   = SRCA_PC;
        src_b_sel   = SRCB_RS2;
        alu_op_sel  = ALUOP_ADD;
        result_sel  = RES_ALUOUT;

        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req    = 1'b1;
                src_b_sel  = SRCB_FOUR;
                result_sel = RES_ALU;
                // IR/OldPC and PC+4 commit only on the cycle memory delivers.
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) begin
                    state_next = ST_DECODE;
                end else if (wd_expire) begin
                    state_next  = ST_TRAP;
                    set_bus_err = 1'b1;
                end
            end

            ST_DECODE: begin
                // Speculative branch target: ALUOut <= OldPC + imm.
                src_a_sel  = SRCA_OLDPC;
                src_b_sel  = SRCB_IMM;
                state_next = decode_next(opcode);
                if (decode_next(opcode) == ST_TRAP) begin
                    set_illegal = 1'b1;
                end
            end

            ST_MEMADR: begin
                src_a_sel  = SRCA_RS1;
                src_b_sel  = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
            end

            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = ST_MEMWB;
                end else if (wd_expire) begin
                    state_next  = ST_TRAP;
                    set_bus_err = 1'b1;
                end
            end

            ST_MEMWB: begin
                result_sel = RES_MEMDATA;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end

            ST_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) begin
                    state_next = ST_FETCH;
                end else if (wd_expire) begin
                    state_next  = ST_TRAP;
                    set_bus_err = 1'b1;
                end
            end

            ST_EXECR: begin
                src_a_sel  = SRCA_RS1;
                src_b_sel  = SRCB_RS2;
                alu_op_sel = ALUOP_RTYPE;
                state_next = ST_ALUWB;
            end

            ST_EXECI: begin
                src_a_sel  = SRCA_RS1;
                src_b_sel  = SRCB_IMM;
                alu_op_sel = ALUOP_ITYPE;
                state_next = ST_ALUWB;
            end

            ST_ALUWB: begin
                result_sel = RES_ALUOUT;
                reg_write  = 1'b1;
                state_next = ST_FETCH;
            end

            ST_BRANCH: begin
                // PC takes the target computed in DECODE only if the compare says so.
                src_a_sel  = SRCA_RS1;
                src_b_sel  = SRCB_RS2;
                alu_op_sel = ALUOP_BRANCH;
                result_sel = RES_ALUOUT;
                pc_write   = br_taken;
                state_next = ST_FETCH;
            end

            ST_JAL: begin
                // PC <= ALUOut (target) while the ALU forms the link value OldPC+4.
                src_a_sel  = SRCA_OLDPC;
                src_b_sel  = SRCB_FOUR;
                result_sel = RES_ALUOUT;
                pc_write   = 1'b1;
                state_next = ST_ALUWB;
            end

            ST_JALR: begin
                // Overwrites ALUOut with rs1+imm, then reuses the JAL sequence.
                src_a_sel  = SRCA_RS1;
                src_b_sel  = SRCB_IMM;
                state_next = ST_JAL;
            end

            ST_LUI: begin
                src_a_sel  = SRCA_ZERO;
                src_b_sel  = SRCB_IMM;
                state_next = ST_ALUWB;
            end

            ST_AUIPC: begin
                src_a_sel  = SRCA_OLDPC;
                src_b_sel  = SRCB_IMM;
                state_next = ST_ALUWB;
            end

            ST_TRAP: begin
                state_next = ST_TRAP;
            end

            default: begin
                state_next = ST_TRAP;
            end
        endcase
    end

    assign alu_src_a  = src_a_sel;
    assign alu_src_b  = src_b_sel;
    assign alu_op     = alu_op_sel;
    assign result_src = result_sel;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm. A driver walks each instruction through the
// step list its class needs, pushing the expected control word for every
// cycle into a scoreboard; a monitor pops and compares on the falling edge.
module tb_multicycle_ctrl_fsm;

    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
    logic        illegal, bus_err;

    multicycle_ctrl_fsm #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .br_taken   (br_taken),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .illegal    (illegal),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic [1:0] rs;
        logic       illegal;
        logic       bus_err;
    } ctrl_t;

    typedef enum {
        K_IDLE, K_FETCH, K_DECODE, K_MEMADR, K_MEMREAD, K_MEMWB, K_MEMWRITE,
        K_EXECR, K_EXECI, K_ALUWB, K_BRANCH, K_JAL, K_JALR, K_LUI, K_AUIPC, K_TRAP
    } step_e;

    typedef struct {
        ctrl_t w;
        step_e k;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_illegal = 1'b0;
    logic exp_bus_err = 1'b0;
    bit   trapped     = 1'b0;

    // Control word each step must present, read straight off the step table.
    function automatic ctrl_t ctrl_of(step_e k, logic rdy, logic br);
        ctrl_t c;
        c = '0;
        c.illegal = exp_illegal;
        c.bus_err = exp_bus_err;
        case (k)
            K_FETCH:    begin c.mem_req = 1; c.b = 2'b10; c.rs = 2'b10;
                              c.ir_write = rdy; c.pc_write = rdy; end
            K_DECODE:   begin c.a = 2'b01; c.b = 2'b01; end
            K_MEMADR:   begin c.a = 2'b10; c.b = 2'b01; end
            K_MEMREAD:  begin c.mem_req = 1; c.adr_src = 1; end
            K_MEMWB:    begin c.rs = 2'b01; c.reg_write = 1; end
            K_MEMWRITE: begin c.mem_req = 1; c.adr_src = 1; c.mem_we = 1; end
            K_EXECR:    begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b10; end
            K_EXECI:    begin c.a = 2'b10; c.b = 2'b01; c.op = 2'b11; end
            K_ALUWB:    begin c.rs = 2'b00; c.reg_write = 1; end
            K_BRANCH:   begin c.a = 2'b10; c.b = 2'b00; c.op = 2'b01; c.pc_write = br; end
            K_JAL:      begin c.a = 2'b01; c.b = 2'b10; c.pc_write = 1; end
            K_JALR:     begin c.a = 2'b10; c.b = 2'b01; end
            K_LUI:      begin c.a = 2'b11; c.b = 2'b01; end
            K_AUIPC:    begin c.a = 2'b01; c.b = 2'b01; end
            default:    ;
        endcase
        return c;
    endfunction

    // One cycle: scramble inputs the step must ignore, record the expectation, advance.
    task automatic step(step_e k);
        exp_t e;
        if (!(k inside {K_FETCH, K_MEMREAD, K_MEMWRITE})) mem_ready = 1'($urandom);
        if (k != K_BRANCH) br_taken = 1'($urandom);
        e.w = ctrl_of(k, mem_ready, br_taken);
        e.k = k;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Memory access with a given number of not-ready cycles before ready.
    task automatic mem_step(step_e k, int waits);
        mem_ready = 1'b0;
        for (int i = 0; i < waits && i < WAIT_MAX; i++) step(k);
        if (waits >= WAIT_MAX) begin
            exp_bus_err = 1'b1;
            trapped     = 1'b1;
        end else begin
            mem_ready = 1'b1;
            step(k);
            mem_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_illegal = 1'b0;
        exp_bus_err = 1'b0;
        trapped     = 1'b0;
        step(K_IDLE);
        step(K_IDLE);
        rst = 1'b0;
        step(K_IDLE);
    endtask

    // Full instruction; any trap is observed for a few cycles and then cleared by reset.
    task automatic run_instr(logic [31:0] ins, logic br, int fw, int mw);
        instr = ins;
        mem_step(K_FETCH, fw);
        if (!trapped) begin
            step(K_DECODE);
            case (ins[6:0])
                7'b0000011: begin
                    step(K_MEMADR);
                    mem_step(K_MEMREAD, mw);
                    if (!trapped) step(K_MEMWB);
                end
                7'b0100011: begin step(K_MEMADR); mem_step(K_MEMWRITE, mw); end
                7'b0110011: begin step(K_EXECR); step(K_ALUWB); end
                7'b0010011: begin step(K_EXECI); step(K_ALUWB); end
                7'b1100011: begin br_taken = br; step(K_BRANCH); end
                7'b1101111: begin step(K_JAL); step(K_ALUWB); end
                7'b1100111: begin step(K_JALR); step(K_JAL); step(K_ALUWB); end
                7'b0110111: begin step(K_LUI); step(K_ALUWB); end
                7'b0010111: begin step(K_AUIPC); step(K_ALUWB); end
                default: begin exp_illegal = 1'b1; trapped = 1'b1; end
            endcase
        end
        if (trapped) begin
            repeat (3) step(K_TRAP);
            do_reset();
        end
    endtask

    // Monitor: every scheduled cycle is compared mid-cycle against the scoreboard.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t  e;
            ctrl_t got;
            e   = sb.pop_front();
            got = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, alu_op, result_src, illegal, bus_err};
            n_checks++;
            if (got === e.w) n_pass++;
            else $display("FAIL %s @%0t: got %b expected %b", e.k.name(), $time, got, e.w);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                  7'b0010111};

    initial begin
        logic [31:0] rnd;
        logic [6:0]  op;
        rst = 1'b1; instr = '0; br_taken = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Directed cases.
        run_instr(32'h002081B3, 1'b0, 0, 0);   // add x3,x1,x2
        run_instr(32'h0080A283, 1'b0, 0, 3);   // lw x5,8(x1), three waits in MEMREAD
        run_instr(32'h00208463, 1'b1, 0, 0);   // beq taken
        run_instr(32'h00208463, 1'b0, 0, 0);   // beq not taken
        run_instr(32'h0000007F, 1'b0, 0, 0);   // unsupported opcode
        run_instr(32'h002081B3, 1'b0, 4, 0);   // fetch never ready -> bus error
        run_instr(32'h002081B3, 1'b0, 3, 0);   // ready on the last allowed cycle
        run_instr(32'h0000006F, 1'b0, 0, 0);   // jal
        run_instr(32'h000080E7, 1'b0, 0, 0);   // jalr
        run_instr(32'h0010A023, 1'b0, 1, 4);   // store stalls out -> bus error

        // Reset while a store is waiting on memory.
        instr = 32'h0010A023;
        mem_step(K_FETCH, 0);
        step(K_DECODE);
        step(K_MEMADR);
        mem_ready = 1'b0;
        step(K_MEMWRITE);
        do_reset();

        // Randomised instruction stream.
        for (int n = 0; n < 250; n++) begin
            rnd = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                op = rnd[6:0];
                foreach (legal_ops[j]) if (legal_ops[j] == op) op = 7'h7F;
            end else begin
                op = legal_ops[$urandom_range(0, 8)];
            end
            run_instr({rnd[31:7], op}, 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? WAIT_MAX : $urandom_range(0, 2),
                      ($urandom_range(0, 19) == 0) ? WAIT_MAX : $urandom_range(0, 3));
        end

        @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
